vga_timing_monitor: RTL and testbench

- Synthesizable, parametrised checker for VGA sync outputs. It measures HS/VS periods and pulse widths against configured timing, and reports lock plus sticky error flags.
- Sits beside the VGA output stage of the maze top. Usable on-chip through LEDs, and as a self-checking monitor in simulation benches.
- Generalises the fixed 640x480@60 check to any mode and either sync polarity.

---
 rtl/vga_mon_pkg.sv | 38 +++
 rtl/vga_mon_sync_meas.sv | 44 ++++
 rtl/vga_timing_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_mon_pkg.sv
// Shared types, default 640x480@60 timing and frame-size helpers for the
// VGA sync timing monitor.
package vga_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_e;

   // One bit per error class; raised only on the tick the error is detected.
   typedef struct packed {
      logic hper;
      logic hwid;
      logic vper;
      logic vwid;
   } mon_err_t;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_mon_sync_meas.sv
// Per-sync-line front end: registers the sync input on each pixel tick,
// produces active/release edge pulses (valid for one tick) and counts how
// many ticks the line has been sampled at its active level.
module vga_mon_sync_meas #(
   parameter bit          POL   = 1'b0,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic             sync,
   output logic             act_edge,
   output logic             rel_edge,
   output logic [CNT_W-1:0] w_cnt
);

   logic smp;
   logic act_now;
   logic act_q;

   assign act_now = (sync == POL);
   assign act_q   = (smp == POL);

   // Sample, edge pulses and width counter advance only on pixel ticks. The
   // sample resets to the inactive level so no release is seen before an
   // active edge; the width holds after release until the next pulse starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp      <= ~POL;
         act_edge <= 1'b0;
         rel_edge <= 1'b0;
         w_cnt    <= '0;
      end else if (pix_en) begin
         smp      <= sync;
         act_edge <= act_now & ~act_q;
         rel_edge <= ~act_now & act_q;
         if (act_now && !act_q)
            w_cnt <= CNT_W'(1);
         else if (act_now && (w_cnt != '1))
            w_cnt <= w_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_monitor.sv
// VGA sync timing monitor: checks HS/VS period and pulse width against the
// configured mode, reports lock and sticky error flags.
// Optional macro VGA_MON_STATS_EN enables the saturating error-event counter
// on err_count; without it err_count is tied to zero.
module vga_timing_monitor
   import vga_mon_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   input  logic        hs,
   input  logic        vs,
   output logic        locked,
   output logic        err_hperiod,
   output logic        err_hwidth,
   output logic        err_vperiod,
   output logic        err_vwidth,
   output logic [15:0] err_count,
   input  logic        clr_err
);

   localparam int unsigned H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int unsigned NUM_SYNC = 2;

   localparam logic [CNT_W-1:0] H_TOT  = CNT_W'(H_TOTAL);
   localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(2 * H_TOTAL);
   localparam logic [CNT_W-1:0] V_TOT  = CNT_W'(V_TOTAL);
   localparam logic [CNT_W-1:0] HW_EXP = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VW_EXP = CNT_W'(V_SYNC * H_TOTAL);

   // lane 0 = hs, lane 1 = vs
   logic [NUM_SYNC-1:0]            sync_in;
   logic [NUM_SYNC-1:0]            act_edge;
   logic [NUM_SYNC-1:0]            rel_edge;
   logic [NUM_SYNC-1:0][CNT_W-1:0] w_cnt;

   assign sync_in = {vs, hs};

   for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
      vga_mon_sync_meas #(
         .POL   (i == 0 ? HS_POL : VS_POL),
         .CNT_W (CNT_W)
      ) u_meas (
         .clk      (clk),
         .rst_n    (rst_n),
         .pix_en   (pix_en),
         .sync     (sync_in[i]),
         .act_edge (act_edge[i]),
         .rel_edge (rel_edge[i]),
         .w_cnt    (w_cnt[i])
      );
   end

   logic h_act, h_rel, v_act, v_rel;
   assign h_act = pix_en & act_edge[0];
   assign h_rel = pix_en & rel_edge[0];
   assign v_act = pix_en & act_edge[1];
   assign v_rel = pix_en & rel_edge[1];

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_seen;
   logic             h_timeout;
   mon_state_e       state_q, state_d;
   logic             frame_err_q, frame_err_d;
   mon_err_t         err_ev;
   logic             any_err;

   // Fires once, on the tick the line counter would reach its ceiling.
   assign h_timeout = pix_en & ~h_act & (h_cnt == H_MAX - 1'b1);

   // Error events for this tick; a coincident HS edge counts toward the frame.
   always_comb begin
      err_ev      = '0;
      err_ev.hper = h_timeout | (h_act & h_seen & (h_cnt != H_TOT));
      err_ev.hwid = h_rel & (w_cnt[0] != HW_EXP);
      err_ev.vper = v_act & (state_q != IDLE) & ((v_cnt + CNT_W'(h_act)) != V_TOT);
      err_ev.vwid = v_rel & (w_cnt[1] != VW_EXP);
   end

   assign any_err = |err_ev;

   // Line-period counter; forgets the previous edge after a timeout so the
   // first edge of a resumed stream is not judged against a stale count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt  <= '0;
         h_seen <= 1'b0;
      end else if (pix_en) begin
         if (h_act)
            h_cnt <= CNT_W'(1);
         else if (h_cnt != H_MAX)
            h_cnt <= h_cnt + 1'b1;
         if (h_timeout)
            h_seen <= 1'b0;
         else if (h_act)
            h_seen <= 1'b1;
      end
   end

   // Lines per frame, restarted at every VS active edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         v_cnt <= '0;
      else if (v_act)
         v_cnt <= '0;
      else if (h_act && (v_cnt != '1))
         v_cnt <= v_cnt + 1'b1;
   end

   // FSM state and per-frame error memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next state: lock after one clean VS-to-VS frame, fall back on errors.
   always_comb begin
      state_d     = state_q;
      frame_err_d = frame_err_q;
      if (h_timeout) begin
         state_d     = IDLE;
         frame_err_d = 1'b0;
      end else if (pix_en) begin
         case (state_q)
            IDLE: begin
               if (v_act) begin
                  state_d     = MEASURE;
                  frame_err_d = any_err;
               end
            end
            MEASURE: begin
               if (v_act) begin
                  if (!(frame_err_q || any_err))
                     state_d = LOCKED;
                  frame_err_d = 1'b0;
               end else if (any_err) begin
                  frame_err_d = 1'b1;
               end
            end
            LOCKED: begin
               // An error on a VS edge opens a fresh frame, so it stays clean.
               if (any_err) begin
                  state_d     = MEASURE;
                  frame_err_d = ~v_act;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign locked = (state_q == LOCKED);

   // Sticky flags; a new error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_hperiod <= 1'b0;
         err_hwidth  <= 1'b0;
         err_vperiod <= 1'b0;
         err_vwidth  <= 1'b0;
      end else begin
         if (err_ev.hper)  err_hperiod <= 1'b1;
         else if (clr_err) err_hperiod <= 1'b0;
         if (err_ev.hwid)  err_hwidth  <= 1'b1;
         else if (clr_err) err_hwidth  <= 1'b0;
         if (err_ev.vper)  err_vperiod <= 1'b1;
         else if (clr_err) err_vperiod <= 1'b0;
         if (err_ev.vwid)  err_vwidth  <= 1'b1;
         else if (clr_err) err_vwidth  <= 1'b0;
      end
   end

`ifdef VGA_MON_STATS_EN
   logic [15:0] err_cnt_q;

   // One count per tick carrying any error, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt_q <= '0;
      else if (clr_err)
         err_cnt_q <= any_err ? 16'd1 : 16'd0;
      else if (any_err && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced video mode
// (32 ticks/line, 15 lines/frame) so whole frames stay short. A second
// instance with active-high syncs watches the inverted stream.
module tb_vga_timing_monitor;
   import vga_mon_pkg::*;

   localparam int HV = 16, HF = 4, HSY = 8, HB = 4;
   localparam int VV = 8,  VF = 2, VSY = 2, VB = 3;
   localparam int HT = HV + HF + HSY + HB;
`ifdef VGA_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk, rst_n, pix_en, hs, vs, clr_err;
   logic        locked, err_hperiod, err_hwidth, err_vperiod, err_vwidth;
   logic [15:0] err_count;
   logic        hs_p, vs_p;
   logic        locked_p, err_hperiod_p, err_hwidth_p, err_vperiod_p, err_vwidth_p;
   logic [15:0] err_count_p;

   int n_tests = 0;
   int n_fail  = 0;

   assign hs_p = ~hs;
   assign vs_p = ~vs;

   vga_timing_monitor #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs(hs), .vs(vs),
      .locked(locked), .err_hperiod(err_hperiod), .err_hwidth(err_hwidth),
      .err_vperiod(err_vperiod), .err_vwidth(err_vwidth),
      .err_count(err_count), .clr_err(clr_err)
   );

   vga_timing_monitor #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(16)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs(hs_p), .vs(vs_p),
      .locked(locked_p), .err_hperiod(err_hperiod_p), .err_hwidth(err_hwidth_p),
      .err_vperiod(err_vperiod_p), .err_vwidth(err_vwidth_p),
      .err_count(err_count_p), .clr_err(clr_err)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One pixel tick: inputs change on a falling edge, pix_en lasts one clock.
   task automatic tick(input logic h, input logic v);
      @(negedge clk);
      pix_en = 1'b1;
      hs     = h;
      vs     = v;
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   // Active-low stream; short_ln loses its last back-porch tick, hsw_ln has a
   // one-tick-short HS pulse, vs_lines sets the VS pulse length in lines.
   task automatic frame(input int nlines, input int short_ln, input int hsw_ln, input int vs_lines);
      for (int l = 0; l < nlines; l++) begin
         int   len;
         int   hw;
         logic va;
         len = (l == short_ln) ? HT - 1 : HT;
         hw  = (l == hsw_ln) ? HSY - 1 : HSY;
         va  = (l >= VV + VF) && (l < VV + VF + vs_lines);
         for (int t = 0; t < len; t++) begin
            logic ha;
            ha = (t >= HV + HF) && (t < HV + HF + hw);
            tick(~ha, ~va);
         end
      end
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk({tag, "_hper"}, err_hperiod, exp[3]);
      chk({tag, "_hwid"}, err_hwidth,  exp[2]);
      chk({tag, "_vper"}, err_vperiod, exp[1]);
      chk({tag, "_vwid"}, err_vwidth,  exp[0]);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; clr_err = 1'b0;
      #5;
      chk("rst_locked", locked, 0);
      chk_flags("rst", 4'b0000);
      chk("rst_cnt", err_count, 0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      #35 rst_n = 1'b1;

      // Acquire lock: first VS edge -> MEASURE, second -> LOCKED.
      frame(15, -1, -1, 2);
      chk("f0_locked", locked, 0);
      frame(15, -1, -1, 2);
      chk("f1_locked", locked, 1);
      chk_flags("f1", 4'b0000);
      chk("pol_locked", locked_p, 1);
      chk("pol_flags", {err_hperiod_p, err_hwidth_p, err_vperiod_p, err_vwidth_p}, 0);

      // Short line: period error, lock lost, regained on the following frame.
      frame(15, 3, -1, 2);
      chk("short_hper", err_hperiod, 1);
      chk("short_locked", locked, 0);
      frame(15, -1, -1, 2);
      chk("relock", locked, 1);
      chk("short_sticky", err_hperiod, 1);

      // Pulse widths.
      frame(15, -1, 5, 2);
      chk("hw_err", err_hwidth, 1);
      chk("hw_locked", locked, 0);
      frame(15, -1, -1, 3);
      chk("vw_err", err_vwidth, 1);
      chk("vw_locked", locked, 0);
      chk("cnt3", err_count, STATS ? 3 : 0);

      // 14-line frame caught at the next VS edge.
      frame(14, -1, -1, 2);
      chk("f14_vper", err_vperiod, 0);
      frame(15, -1, -1, 2);
      chk_flags("vper", 4'b1111);

      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      chk_flags("clr", 4'b0000);
      chk("clr_cnt", err_count, 0);

      frame(15, -1, -1, 2);
      chk("clr_relock", locked, 1);

      // HS timeout: 52 idle ticks leave the count at 2*H_TOTAL-1, one more trips it.
      for (int k = 0; k < 52; k++) tick(1'b1, 1'b1);
      chk("to_before", err_hperiod, 0);
      chk("to_locked_before", locked, 1);
      tick(1'b1, 1'b1);
      chk("to_hper", err_hperiod, 1);
      chk("to_locked", locked, 0);
      chk("to_state", 32'(dut.state_q), 32'(IDLE));

      frame(15, -1, -1, 2);
      frame(15, -1, -1, 2);
      chk("to_relock", locked, 1);
      chk("to_cnt", err_count, STATS ? 1 : 0);

      // Asynchronous reset mid-frame, between clock edges.
      frame(5, -1, -1, 2);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk_flags("arst", 4'b0000);
      chk("arst_cnt", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
